// File: rtl/wave_voice_alloc.sv
// wave_voice_alloc: voice allocator and DMA trigger scheduler for the wave
// sample players. Queues play requests, assigns each one to a free voice or
// drops it, and issues a one-cycle trigger with the start address. Also owns
// the ROM interleave slot counter and the global stop sequence.
// Optional feature: define WAVE_VOICE_STEAL_EN to let a request steal the
// busy voice with the lowest stored priority when no voice is free.
module wave_voice_alloc #(
    parameter int NUM_VOICES = 8,
    parameter int ADDR_W     = 16,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                  I_CLK,
    input  logic                  I_RST,
    input  logic                  I_REQ_VALID,
    output logic                  O_REQ_READY,
    input  logic [ADDR_W-1:0]     I_REQ_ADDR,
    input  logic [1:0]            I_REQ_PRIO,
    input  logic                  I_STOP_ALL,
    input  logic [NUM_VOICES-1:0] I_VOICE_DONE,
    output logic [3:0]            O_H_CNT,
    output logic [NUM_VOICES-1:0] O_DMA_TRIG,
    output logic [NUM_VOICES-1:0] O_DMA_STOP,
    output logic [ADDR_W-1:0]     O_DMA_ADDR,
    output logic [NUM_VOICES-1:0] O_BUSY,
    output logic                  O_DROP
);
    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    typedef enum logic [1:0] {ST_IDLE, ST_ALLOC, ST_TRIG, ST_STOP} state_t;

    state_t                r_state, w_state_nxt;
    logic [ADDR_W-1:0]     r_fifo_addr [FIFO_DEPTH];
    logic [1:0]            r_fifo_prio [FIFO_DEPTH];
    logic [PW-1:0]         r_wr_ptr, r_rd_ptr;
    logic [PW:0]           r_count;
    logic [ADDR_W-1:0]     r_wk_addr;
    logic [1:0]            r_wk_prio;
    logic [VW-1:0]         r_target, w_target_nxt;
    logic [NUM_VOICES-1:0] r_busy;
    logic [1:0]            r_prio [NUM_VOICES];
    logic                  r_drop, w_drop_nxt;
    logic [3:0]            r_h_cnt;

    logic                  w_push, w_pop, w_stop_go, w_full;
    logic                  w_any_free, w_can_steal;
    logic [VW-1:0]         w_free_idx, w_min_idx;
    logic [NUM_VOICES-1:0] w_trig_vec;

    assign w_full      = (r_count == (PW+1)'(FIFO_DEPTH));
    assign w_stop_go   = I_STOP_ALL && (r_state != ST_STOP);
    // A stop in the same cycle as a handshake wins: the request is not stored.
    assign w_push      = I_REQ_VALID && O_REQ_READY && !I_STOP_ALL;
    assign w_trig_vec  = (r_state == ST_TRIG) ? (NUM_VOICES'(1) << r_target) : '0;

    assign O_REQ_READY = !w_full && (r_state != ST_STOP);
    assign O_H_CNT     = r_h_cnt;
    assign O_DMA_TRIG  = w_trig_vec;
    assign O_DMA_ADDR  = (r_state == ST_TRIG) ? r_wk_addr : '0;
    assign O_DMA_STOP  = (r_state == ST_STOP) ? r_busy : '0;
    assign O_BUSY      = r_busy;
    assign O_DROP      = r_drop;

    // Free-running ROM interleave slot counter.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        // NOTE: sequential state is assigned with <= so every register samples
        // pre-edge values; = here would create order-dependent races.
        if (I_RST) r_h_cnt <= 4'd0;
        else       r_h_cnt <= r_h_cnt + 4'd1;
    end

    // Request FIFO payload storage.
    always_ff @(posedge I_CLK) begin
        // NOTE: the payload array is not reset; the pointers and count are,
        // so stale entries are never read.
        if (w_push) begin
            r_fifo_addr[r_wr_ptr] <= I_REQ_ADDR;
            r_fifo_prio[r_wr_ptr] <= I_REQ_PRIO;
        end
    end

    // Request FIFO pointers and occupancy; a stop flushes the queue.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (w_stop_go) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) r_wr_ptr <= (r_wr_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= (r_rd_ptr == PW'(FIFO_DEPTH-1)) ? '0 : r_rd_ptr + 1'b1;
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Lowest-index free voice.
    always_comb begin
        w_any_free = 1'b0;
        w_free_idx = '0;
        for (int v = NUM_VOICES-1; v >= 0; v--) begin
            if (!r_busy[v]) begin
                w_any_free = 1'b1;
                w_free_idx = VW'(v);
            end
        end
    end

`ifdef WAVE_VOICE_STEAL_EN
    logic [1:0] w_min_prio;

    // Weakest busy voice (lowest stored priority, ties to lowest index).
    always_comb begin
        w_min_idx  = '0;
        w_min_prio = r_prio[0];
        for (int v = 1; v < NUM_VOICES; v++) begin
            if (r_prio[v] < w_min_prio) begin
                w_min_idx  = VW'(v);
                w_min_prio = r_prio[v];
            end
        end
        w_can_steal = (w_min_prio <= r_wk_prio);
    end
`else
    logic w_unused_prio;

    // Without stealing, stored priorities are kept but never consulted.
    always_comb begin
        w_min_idx     = '0;
        w_can_steal   = 1'b0;
        w_unused_prio = ^r_wk_prio;
        for (int v = 0; v < NUM_VOICES; v++) w_unused_prio = w_unused_prio ^ (^r_prio[v]);
    end
`endif

    // FSM next-state, target selection, pop and drop decisions.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves one unassigned and no latch is inferred.
        w_state_nxt  = r_state;
        w_target_nxt = r_target;
        w_drop_nxt   = 1'b0;
        w_pop        = 1'b0;
        if (w_stop_go) begin
            w_state_nxt = ST_STOP;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_count != '0) begin
                        w_pop       = 1'b1;
                        w_state_nxt = ST_ALLOC;
                    end
                end
                ST_ALLOC: begin
                    if (w_any_free) begin
                        w_target_nxt = w_free_idx;
                        w_state_nxt  = ST_TRIG;
                    end else if (w_can_steal) begin
                        w_target_nxt = w_min_idx;
                        w_state_nxt  = ST_TRIG;
                    end else begin
                        w_drop_nxt  = 1'b1;
                        w_state_nxt = ST_IDLE;
                    end
                end
                ST_TRIG: w_state_nxt = ST_IDLE;
                ST_STOP: if (r_busy == '0) w_state_nxt = ST_IDLE;
                default: w_state_nxt = ST_IDLE;
            endcase
        end
    end

    // FSM state, working request registers, target and drop pulse.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_state   <= ST_IDLE;
            r_target  <= '0;
            r_drop    <= 1'b0;
            r_wk_addr <= '0;
            r_wk_prio <= 2'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_target <= w_target_nxt;
            r_drop   <= w_drop_nxt;
            if (w_pop) begin
                r_wk_addr <= r_fifo_addr[r_rd_ptr];
                r_wk_prio <= r_fifo_prio[r_rd_ptr];
            end
        end
    end

    // Per-voice busy flag and stored priority; a trigger exit beats a done.
    always_ff @(posedge I_CLK or posedge I_RST) begin
        if (I_RST) begin
            r_busy <= '0;
            for (int v = 0; v < NUM_VOICES; v++) r_prio[v] <= 2'd0;
        end else begin
            for (int v = 0; v < NUM_VOICES; v++) begin
                if (w_trig_vec[v]) begin
                    r_busy[v] <= 1'b1;
                    r_prio[v] <= r_wk_prio;
                end else if (I_VOICE_DONE[v]) begin
                    r_busy[v] <= 1'b0;
                    r_prio[v] <= 2'd0;
                end
            end
        end
    end
endmodule

// File: tb/tb_wave_voice_alloc.sv
// Self-checking bench for wave_voice_alloc: directed scenarios plus random
// traffic, with a scoreboard of accepted requests resolved by a monitor.
module tb_wave_voice_alloc;
    localparam int NV = 8;
    localparam int AW = 16;
    localparam int FD = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic [1:0]    req_prio;
    logic          stop_all;
    logic [NV-1:0] voice_done;
    logic [3:0]    h_cnt;
    logic [NV-1:0] dma_trig, dma_stop, busy;
    logic [AW-1:0] dma_addr;
    logic          drop;

    wave_voice_alloc #(.NUM_VOICES(NV), .ADDR_W(AW), .FIFO_DEPTH(FD)) dut (
        .I_CLK(clk), .I_RST(rst),
        .I_REQ_VALID(req_valid), .O_REQ_READY(req_ready),
        .I_REQ_ADDR(req_addr), .I_REQ_PRIO(req_prio),
        .I_STOP_ALL(stop_all), .I_VOICE_DONE(voice_done),
        .O_H_CNT(h_cnt), .O_DMA_TRIG(dma_trig), .O_DMA_STOP(dma_stop),
        .O_DMA_ADDR(dma_addr), .O_BUSY(busy), .O_DROP(drop)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [1:0]    prio;
    } req_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    req_t req_q[$];
    int   trig_cyc[$];
    int   drop_cnt = 0;
    logic [NV-1:0] last_trig = '0;
    bit   saw_not_ready;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Reference model: busy mask and stored priority per voice.
    logic [NV-1:0] m_busy = '0, p_busy = '0;
    int   m_prio[NV], p_prio[NV];
    int   h_prev;
    bit   h_ok = 0;
    int   mon_tgt, mon_min;
    req_t mon_req;

    // Monitor: resolves the oldest accepted request whenever the DUT shows a
    // trigger or a drop, and tracks the voice state it implies.
    always @(negedge clk) begin
        if (rst) begin
            m_busy = '0;
            p_busy = '0;
            for (int v = 0; v < NV; v++) begin m_prio[v] = 0; p_prio[v] = 0; end
            req_q.delete();
            h_ok = 0;
            check("rst_hcnt", h_cnt, 0);
            check("rst_trig", dma_trig, 0);
        end else begin
            if (h_ok) check("h_cnt_step", h_cnt, (h_prev + 1) % 16);
            h_prev = int'(h_cnt);
            h_ok   = 1;
            check("busy_mask", busy, m_busy);
            mon_tgt = -1;
            if (dma_trig != '0 || drop) begin
                if (drop) drop_cnt++;
                if (dma_trig != '0) begin trig_cyc.push_back(cyc); last_trig = dma_trig; end
                if (req_q.size() == 0) begin
                    check("unexpected_event", {23'd0, drop, dma_trig}, 0);
                end else begin
                    mon_req = req_q.pop_front();
                    // Decision was taken one cycle earlier, on that cycle's state.
                    for (int v = NV-1; v >= 0; v--) if (!p_busy[v]) mon_tgt = v;
`ifdef WAVE_VOICE_STEAL_EN
                    if (mon_tgt < 0) begin
                        mon_min = 0;
                        for (int v = 1; v < NV; v++) if (p_prio[v] < p_prio[mon_min]) mon_min = v;
                        if (p_prio[mon_min] <= int'(mon_req.prio)) mon_tgt = mon_min;
                    end
`endif
                    if (mon_tgt >= 0) begin
                        check("trig_vec", dma_trig, 32'(1) << mon_tgt);
                        check("trig_addr", dma_addr, mon_req.addr);
                        check("trig_no_drop", drop, 0);
                    end else begin
                        check("drop_pulse", drop, 1);
                        check("drop_no_trig", dma_trig, 0);
                    end
                end
            end
            p_busy = m_busy;
            p_prio = m_prio;
            for (int v = 0; v < NV; v++)
                if (voice_done[v] && m_busy[v]) begin m_busy[v] = 1'b0; m_prio[v] = 0; end
            if (mon_tgt >= 0) begin
                m_busy[mon_tgt] = 1'b1;
                m_prio[mon_tgt] = int'(mon_req.prio);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [AW-1:0] a, input logic [1:0] p);
        int   n = 0;
        bit   hs = 0;
        req_t t;
        req_valid = 1'b1;
        req_addr  = a;
        req_prio  = p;
        while (!hs && n < 200) begin
            if (!req_ready) saw_not_ready = 1;
            hs = req_ready && !stop_all;
            tick();
            n++;
        end
        req_valid = 1'b0;
        if (hs) begin
            t.addr = a;
            t.prio = p;
            req_q.push_back(t);
        end else begin
            check("send_timeout", 0, 1);
        end
    endtask

    task automatic pulse_done(input logic [NV-1:0] m);
        voice_done = m;
        tick();
        voice_done = '0;
    endtask

    task automatic wait_drain();
        int n = 0;
        while (req_q.size() != 0 && n < 200) begin tick(); n++; end
        check("drain_timeout", req_q.size(), 0);
        tick();
        tick();
    endtask

    task automatic wait_trig();
        int n = 0;
        while (dma_trig == '0 && n < 20) begin tick(); n++; end
        check("trig_timeout", (dma_trig != '0), 1);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    int d0;
    bit hs_r;
    req_t tr;
    initial begin
        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_prio = 2'd0;
        stop_all = 1'b0; voice_done = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ready", req_ready, 1);
        check("rst_busy", busy, 0);
        check("rst_stop", dma_stop, 0);
        check("rst_drop", drop, 0);
        check("rst_addr", dma_addr, 0);
        rst = 1'b0;
        tick();

        // Single request: latency and trigger contents.
        send(16'h1234, 2'd1);
        check("t1_e0_trig", dma_trig, 0);
        tick();
        check("t1_e1_trig", dma_trig, 0);
        tick();
        check("t1_trig", dma_trig, 8'h01);
        check("t1_addr", dma_addr, 16'h1234);
        tick();
        check("t1_trig_low", dma_trig, 0);
        check("t1_busy", busy, 8'h01);
        pulse_done(8'h01);

        // Nine back-to-back requests at priority 0.
        saw_not_ready = 0;
        trig_cyc.delete();
        d0 = drop_cnt;
        for (int i = 0; i < 9; i++) send(AW'(16'h2000 + i), 2'd0);
        wait_drain();
        check("b2b_ready_low", saw_not_ready, 1);
        check("b2b_busy", busy, 8'hFF);
`ifdef WAVE_VOICE_STEAL_EN
        check("b2b_trig_count", trig_cyc.size(), 9);
        check("b2b_drops", drop_cnt - d0, 0);
`else
        check("b2b_trig_count", trig_cyc.size(), 8);
        check("b2b_drops", drop_cnt - d0, 1);
`endif
        for (int i = 1; i < 8 && i < trig_cyc.size(); i++)
            check("b2b_spacing", trig_cyc[i] - trig_cyc[i-1], 3);
        pulse_done(8'hFF);
        tick();
        check("b2b_cleared", busy, 0);

        // Priority pattern {2,2,0,1,3,3,3,3}, then prio 1 and prio 0 requests.
        send(16'h3000, 2'd2); send(16'h3001, 2'd2); send(16'h3002, 2'd0); send(16'h3003, 2'd1);
        send(16'h3004, 2'd3); send(16'h3005, 2'd3); send(16'h3006, 2'd3); send(16'h3007, 2'd3);
        wait_drain();
        d0 = drop_cnt;
        send(16'h3100, 2'd1);
        wait_drain();
`ifdef WAVE_VOICE_STEAL_EN
        check("steal_target", last_trig, 8'h04);
        check("steal_no_drop", drop_cnt - d0, 0);
`else
        check("nosteal_drop", drop_cnt - d0, 1);
`endif
        d0 = drop_cnt;
        send(16'h3200, 2'd0);
        wait_drain();
        check("weak_req_drop", drop_cnt - d0, 1);
        pulse_done(8'hFF);

        // Done on voice 3 in the cycle its trigger exits.
        send(16'h4000, 2'd0); send(16'h4001, 2'd0); send(16'h4002, 2'd0);
        wait_drain();
        send(16'h4003, 2'd2);
        wait_trig();
        check("v3_trig", dma_trig, 8'h08);
        pulse_done(8'h08);
        check("v3_set_wins", busy[3], 1);
        check("v3_busy_mask", busy, 8'h0F);
        pulse_done(8'hFF);

        // Global stop with requests pending and a handshake in the stop cycle.
        send(16'h5000, 2'd0); send(16'h5001, 2'd0); send(16'h5002, 2'd0);
        wait_drain();
        pulse_done(8'h02);
        check("stop_pre_busy", busy, 8'h05);
        send(16'h5100, 2'd1);
        send(16'h5101, 2'd1);
        req_valid = 1'b1; req_addr = 16'h5102; req_prio = 2'd3;
        stop_all  = 1'b1;
        req_q.delete();
        tick();
        stop_all = 1'b0; req_valid = 1'b0;
        check("stop_ready", req_ready, 0);
        check("stop_level", dma_stop, 8'h05);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("stop_no_trig", dma_trig, 0);
        end
        pulse_done(8'h05);
        check("stop_level_clr", dma_stop, 0);
        tick();
        check("stop_exit_ready", req_ready, 1);
        repeat (6) begin
            tick();
            check("stop_flushed", dma_trig, 0);
        end

        // Random traffic against the model.
        for (int c = 0; c < 500; c++) begin
            if (!req_valid && $urandom_range(0, 2) == 0) begin
                req_valid = 1'b1;
                req_addr  = AW'($urandom);
                req_prio  = 2'($urandom_range(0, 3));
            end
            voice_done = ($urandom_range(0, 5) == 0) ? (NV'(1) << $urandom_range(0, NV-1)) : '0;
            hs_r = req_valid && req_ready;
            tick();
            if (hs_r) begin
                tr.addr = req_addr;
                tr.prio = req_prio;
                req_q.push_back(tr);
                req_valid = 1'b0;
            end
        end
        voice_done = '0;
        req_valid  = 1'b0;
        wait_drain();
        pulse_done(8'hFF);

        // Reset in the middle of a trigger.
        send(16'h6000, 2'd3);
        wait_trig();
        rst = 1'b1;
        #1;
        check("rst_mid_trig", dma_trig, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_ready", req_ready, 1);
        check("rst_mid_addr", dma_addr, 0);
        tick();
        rst = 1'b0;
        tick();
        send(16'h6001, 2'd0);
        wait_drain();
        check("post_rst_busy", busy, 8'h01);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
